// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8-bit LSB-first UART transmitter, 1 stop bit, valid/ready input handshake.
// Define UART_TX_PARITY_EN to append an even-parity bit after data bit 7 (8E1 instead of 8N1).
module uart_byte_tx #(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   function automatic logic parity8(input logic [7:0] d);
      return ^d;
   endfunction

   logic par_r;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd4
   } state_t;
`endif

   state_t          state_r;
   logic [CW-1:0]   cnt_r;
   logic [2:0]      bit_cnt_r;
   logic [7:0]      shift_r;
   logic            bit_end;

   assign bit_end  = (cnt_r == CNT_LAST);
   assign tx_ready = (state_r == IDLE);
   assign busy     = (state_r != IDLE);

   // Frame sequencer: tx is registered so each bit level is set on the boundary edge itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         tx        <= 1'b1;
         cnt_r     <= '0;
         bit_cnt_r <= 3'd0;
         shift_r   <= 8'h00;
`ifdef UART_TX_PARITY_EN
         par_r     <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               tx <= 1'b1;
               if (tx_valid) begin
                  shift_r   <= tx_data;
                  cnt_r     <= '0;
                  bit_cnt_r <= 3'd0;
                  state_r   <= START;
                  tx        <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  par_r     <= parity8(tx_data);
`endif
               end
            end
            START: begin
               if (bit_end) begin
                  cnt_r   <= '0;
                  state_r <= DATA;
                  tx      <= shift_r[0];
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt_r   <= '0;
                  shift_r <= {1'b0, shift_r[7:1]};
                  if (bit_cnt_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state_r <= PARITY;
                     tx      <= par_r;
`else
                     state_r <= STOP;
                     tx      <= 1'b1;
`endif
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                     tx        <= shift_r[1];
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  cnt_r   <= '0;
                  state_r <= STOP;
                  tx      <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  cnt_r   <= '0;
                  state_r <= IDLE;
                  tx      <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               tx      <= 1'b1;
               cnt_r   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: queue-based line model checked every cycle,
// a bit-sampling receiver, and directed scenarios with hand-computed expectations.
module tb_uart_byte_tx;
   localparam int N = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'hA5;
   logic       tx_valid = 1'b1;
   logic       tx_ready;
   logic       tx;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   uart_byte_tx #(.CLKS_PER_BIT(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx       (tx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Line model: one queue entry per future cycle of the current frame; empty means idle.
   logic model_q[$];
   always @(posedge clk) begin
      if (rst === 1'b1) begin
         model_q.delete();
      end else if (model_q.size() == 0) begin
         if (tx_valid === 1'b1) begin
            for (int k = 0; k < N; k++) model_q.push_back(1'b0);
            for (int b = 0; b < 8; b++)
               for (int k = 0; k < N; k++) model_q.push_back(tx_data[b]);
`ifdef UART_TX_PARITY_EN
            for (int k = 0; k < N; k++) model_q.push_back(^tx_data);
`endif
            for (int k = 0; k < N; k++) model_q.push_back(1'b1);
         end
      end else begin
         void'(model_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("tx_line", tx, (model_q.size() == 0) ? 1'b1 : model_q[0]);
         check("tx_ready", tx_ready, (model_q.size() == 0));
         check("busy", busy, (model_q.size() != 0));
      end
   end

   // Receiver: samples each bit mid-way, records start cycles and decoded bytes.
   logic       rx_bits [0:FB-1];
   logic [7:0] rx_q[$];
   int         start_q[$];
   logic       rx_par = 1'b0;
   bit         rx_active = 1'b0;
   int         rx_cnt = 0;
   logic       prev_tx = 1'b1;
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (tx === 1'b0 && prev_tx === 1'b1) begin
            rx_active = 1'b1;
            rx_cnt = 0;
            start_q.push_back(cyc);
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % N == N / 2) begin
            rx_bits[rx_cnt / N] = tx;
            if (rx_cnt / N == FB - 1) begin
               logic [7:0] b;
               for (int i = 0; i < 8; i++) b[i] = rx_bits[i + 1];
               rx_q.push_back(b);
               rx_par = rx_bits[9];
               rx_active = 1'b0;
            end
         end
      end
      prev_tx = tx;
   end

   task automatic send(input logic [7:0] d, input bit hold, output int acc);
      int w;
      w = 0;
      @(posedge clk); #2;
      tx_data  = d;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && w < 500) begin
         @(posedge clk); #2;
         w++;
      end
      check("handshake_wait", (w < 500), 1'b1);
      @(posedge clk); #1;
      acc = cyc;
      #1;
      if (!hold) tx_valid = 1'b0;
   endtask

   task automatic wait_idle(output int low_cycles);
      int n;
      n = 0;
      @(negedge clk);
      while (tx_ready !== 1'b1 && n < 500) begin
         n++;
         @(negedge clk);
      end
      low_cycles = n;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc2, low, rq0, sq0;
      logic [9:0] a5_bits;

      // Reset held 3 cycles with tx_valid high.
      @(posedge clk); #1;
      chk_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_tx", tx, 1'b1);
         check("rst_ready", tx_ready, 1'b1);
         check("rst_busy", busy, 1'b0);
         if (i < 2) @(posedge clk);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      tx_valid = 1'b0;
      repeat (20) @(posedge clk);
      check("no_frame_after_rst", start_q.size(), 0);

      // Single byte 0xA5.
      rq0 = rx_q.size();
      send(8'hA5, 1'b0, acc);
      wait_idle(low);
      check("a5_ready_low", low, FB * N);
      check("a5_start_latency", start_q[start_q.size() - 1], acc);
      check("a5_byte", rx_q[rq0], 8'hA5);
      a5_bits = 10'b1_1010_0101_0;
      for (int i = 0; i < 9; i++) check("a5_bit", rx_bits[i], a5_bits[i]);
      check("a5_stop", rx_bits[FB - 1], 1'b1);

      // Back-to-back 0x00 then 0xFF with tx_valid held high.
      rq0 = rx_q.size();
      sq0 = start_q.size();
      send(8'h00, 1'b1, acc);
      send(8'hFF, 1'b0, acc2);
      wait_idle(low);
      check("b2b_accept_gap", acc2 - acc, FB * N + 1);
`ifdef UART_TX_PARITY_EN
      check("b2b_start_gap", start_q[sq0 + 1] - start_q[sq0], 45);
`else
      check("b2b_start_gap", start_q[sq0 + 1] - start_q[sq0], 41);
`endif
      check("b2b_count", rx_q.size() - rq0, 2);
      check("b2b_byte0", rx_q[rq0], 8'h00);
      check("b2b_byte1", rx_q[rq0 + 1], 8'hFF);

      // Busy protection: data change and valid pulse mid-frame are ignored.
      rq0 = rx_q.size();
      sq0 = start_q.size();
      send(8'h81, 1'b0, acc);
      repeat (15) @(posedge clk);
      #2;
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      @(posedge clk); #2;
      tx_valid = 1'b0;
      wait_idle(low);
      repeat (60) @(posedge clk);
      check("busy_count", rx_q.size() - rq0, 1);
      check("busy_byte", rx_q[rq0], 8'h81);
      check("busy_starts", start_q.size() - sq0, 1);

      // Reset during data bit 3 of 0x55.
      rq0 = rx_q.size();
      send(8'h55, 1'b0, acc);
      repeat (17) @(posedge clk);
      #2;
      check("mid_line_low", tx, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_tx", tx, 1'b1);
      check("mid_rst_ready", tx_ready, 1'b1);
      check("mid_rst_busy", busy, 1'b0);
      #1;
      rst = 1'b0;
      sq0 = start_q.size();
      repeat (50) @(posedge clk);
      check("mid_no_byte", rx_q.size() - rq0, 0);
      check("mid_no_start", start_q.size() - sq0, 0);

`ifdef UART_TX_PARITY_EN
      rq0 = rx_q.size();
      send(8'h07, 1'b0, acc);
      wait_idle(low);
      check("par07_frame", low, 44);
      check("par07_byte", rx_q[rq0], 8'h07);
      check("par07_bit", rx_par, 1'b1);
      send(8'h03, 1'b0, acc);
      wait_idle(low);
      check("par03_byte", rx_q[rq0 + 1], 8'h03);
      check("par03_bit", rx_par, 1'b0);
`endif

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
